// File: rtl/rx_link_arbiter_if.sv
// Handshake bundle between the per-link RX FIFO read ports, the link arbiter
// and the shared output FIFO.
interface rx_link_arbiter_if #(
    parameter int N_LINKS    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CH_WIDTH   = 3
);
    logic [N_LINKS-1:0]            LINK_EN;
    logic [N_LINKS-1:0]            IN_VALID;
    logic [N_LINKS*DATA_WIDTH-1:0] IN_DATA;
    logic [N_LINKS-1:0]            IN_READY;
    logic                          OUT_VALID;
    logic [DATA_WIDTH-1:0]         OUT_DATA;
    logic [CH_WIDTH-1:0]           OUT_CH;
    logic                          OUT_READY;
    logic [N_LINKS-1:0]            GRANT;
    logic [31:0]                   WORD_CNT;

    modport master (
        output LINK_EN, IN_VALID, IN_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_CH, GRANT, WORD_CNT
    );

    modport slave (
        input  LINK_EN, IN_VALID, IN_DATA, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_CH, GRANT, WORD_CNT
    );
endinterface

// File: rtl/rx_link_arbiter.sv
// Round-robin burst arbiter merging per-link RX data streams into one tagged
// stream with a single-stage output register.
//
// state | meaning
// IDLE  | pick next requesting link after the last-served one; no transfer
// SERVE | pop up to MAX_BURST words from the granted link into the output reg
module rx_link_arbiter #(
    parameter int N_LINKS    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int CH_WIDTH   = 3
) (
    input logic              BUS_CLK,
    input logic              BUS_RST_N,
    rx_link_arbiter_if.slave bus
);
    typedef enum logic {IDLE, SERVE} state_t;

    localparam logic [N_LINKS-1:0] ONE = N_LINKS'(1);

    state_t                state;
    logic [N_LINKS-1:0]    grant;
    logic [CH_WIDTH-1:0]   gidx;
    logic [CH_WIDTH-1:0]   last;
    logic [7:0]            burst_cnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CH_WIDTH-1:0]   out_ch;
    logic [31:0]           word_cnt;

    logic [N_LINKS-1:0]    req;
    logic [DATA_WIDTH-1:0] words [N_LINKS];
    logic [CH_WIDTH-1:0]   pick_idx;
    logic                  pick_found;
    logic                  cur_valid;
    logic                  out_free;
    logic                  xfer;
    logic                  accept;
    logic                  burst_last;

    for (genvar k = 0; k < N_LINKS; k++) begin : g_unpack
        assign words[k] = bus.IN_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req = bus.IN_VALID & bus.LINK_EN;

    // Rotating priority: search upward from the link after the last one served.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= N_LINKS; i++) begin
            cand = (int'(last) + i) % N_LINKS;
            if (!pick_found && req[cand[CH_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CH_WIDTH-1:0];
            end
        end
    end

    assign cur_valid  = bus.IN_VALID[gidx] & bus.LINK_EN[gidx];
    assign out_free   = !out_valid || bus.OUT_READY;
    assign xfer       = (state == SERVE) && cur_valid && out_free;
    assign accept     = out_valid && bus.OUT_READY;
    assign burst_last = (burst_cnt == 8'(MAX_BURST - 1));

    assign bus.IN_READY  = xfer ? grant : '0;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = out_data;
    assign bus.OUT_CH    = out_ch;
    assign bus.GRANT     = grant;
    assign bus.WORD_CNT  = word_cnt;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state     <= IDLE;
            grant     <= '0;
            gidx      <= '0;
            last      <= CH_WIDTH'(N_LINKS - 1);
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            word_cnt  <= '0;
        end else begin
            word_cnt <= word_cnt + {31'b0, accept};

            // A load and a downstream accept may coincide; the load wins.
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= words[gidx];
                out_ch    <= gidx;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (pick_found) begin
                        state <= SERVE;
                        grant <= ONE << pick_idx;
                        gidx  <= pick_idx;
                    end
                end
                SERVE: begin
                    if (!cur_valid) begin
                        state <= IDLE;
                        grant <= '0;
                        last  <= gidx;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (burst_last) begin
                            state <= IDLE;
                            grant <= '0;
                            last  <= gidx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_N)
        $onehot0(bus.IN_READY));
    a_grant_onehot: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_N)
        $onehot0(bus.GRANT));
    a_ready_enabled: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_N)
        (bus.IN_READY & ~bus.LINK_EN) == '0);
endmodule
